// File: rtl/pcie_dma_wr_splitter.sv
// Write-request splitter for the PCIe DMA write-descriptor port.
// Breaks each host-write request into chunks that never cross a MAX_CHUNK
// boundary, tags every chunk with a rolling DMA tag, tracks the chunks in an
// in-order FIFO and emits one completion per request when its last chunk retires.
module pcie_dma_wr_splitter #(
  parameter int PCIE_ADDR_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH  = 48,
  parameter int REQ_LEN_WIDTH   = 20,
  parameter int REQ_TAG_WIDTH   = 8,
  parameter int DMA_TAG_WIDTH   = 8,
  parameter int MAX_CHUNK       = 4096,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PCIE_ADDR_WIDTH-1:0] s_req_pcie_addr,
  input  logic [AXI_ADDR_WIDTH-1:0]  s_req_axi_addr,
  input  logic [REQ_LEN_WIDTH-1:0]   s_req_len,
  input  logic [REQ_TAG_WIDTH-1:0]   s_req_tag,
  input  logic                       s_req_valid,
  output logic                       s_req_ready,
  output logic [PCIE_ADDR_WIDTH-1:0] m_desc_pcie_addr,
  output logic [AXI_ADDR_WIDTH-1:0]  m_desc_axi_addr,
  output logic [15:0]                m_desc_len,
  output logic [DMA_TAG_WIDTH-1:0]   m_desc_tag,
  output logic                       m_desc_valid,
  input  logic                       m_desc_ready,
  input  logic [DMA_TAG_WIDTH-1:0]   s_status_tag,
  input  logic [3:0]                 s_status_error,
  input  logic                       s_status_valid,
  output logic [REQ_TAG_WIDTH-1:0]   m_cpl_tag,
  output logic [3:0]                 m_cpl_error,
  output logic                       m_cpl_valid,
  output logic                       err_tag_mismatch,
  output logic                       err_unexpected,
  output logic                       err_zero_len
);

  localparam int OFF_W = $clog2(MAX_CHUNK);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                     state_q, state_d;
  logic [PCIE_ADDR_WIDTH-1:0] pcie_q, pcie_d;
  logic [AXI_ADDR_WIDTH-1:0]  axi_q, axi_d;
  logic [REQ_LEN_WIDTH-1:0]   rem_q, rem_d;
  logic [15:0]                chunk_q, chunk_d;
  logic [REQ_TAG_WIDTH-1:0]   req_tag_q, req_tag_d;
  logic [DMA_TAG_WIDTH-1:0]   dma_tag_q, dma_tag_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]             cnt_q, cnt_d;
  logic [3:0]                 err_acc_q, err_acc_d;
  logic                       cpl_valid_q, cpl_valid_d;
  logic [REQ_TAG_WIDTH-1:0]   cpl_tag_q, cpl_tag_d;
  logic [3:0]                 cpl_error_q, cpl_error_d;
  logic                       err_mm_q, err_mm_d;
  logic                       err_unexp_q, err_unexp_d;
  logic                       err_zero_q, err_zero_d;

  // Outstanding-chunk FIFO storage (data only, no reset needed)
  logic [DMA_TAG_WIDTH-1:0] fifo_dtag [MAX_OUTSTANDING];
  logic [REQ_TAG_WIDTH-1:0] fifo_rtag [MAX_OUTSTANDING];
  logic                     fifo_last [MAX_OUTSTANDING];

  logic                       fifo_full, fifo_empty;
  logic                       req_fire, desc_fire, desc_last, status_pop;
  logic [PCIE_ADDR_WIDTH-1:0] pcie_nxt;
  logic [AXI_ADDR_WIDTH-1:0]  axi_nxt;
  logic [REQ_LEN_WIDTH-1:0]   rem_nxt;
  logic [DMA_TAG_WIDTH-1:0]   head_dtag;
  logic [REQ_TAG_WIDTH-1:0]   head_rtag;
  logic                       head_last;
  logic [3:0]                 eff_err;

  // Bytes allowed in the next chunk: up to the next MAX_CHUNK boundary, capped by what remains.
  function automatic logic [15:0] chunk_len(input logic [OFF_W-1:0] off,
                                            input logic [REQ_LEN_WIDTH-1:0] rem);
    logic [31:0] space;
    logic [31:0] r;
    space = 32'(MAX_CHUNK) - 32'(off);
    r     = 32'(rem);
    if (r < space) space = r;
    return space[15:0];
  endfunction

  assign fifo_full   = (cnt_q == (PTR_W+1)'(MAX_OUTSTANDING));
  assign fifo_empty  = (cnt_q == '0);
  assign s_req_ready  = (state_q == IDLE) && !rst;
  // A full FIFO stalls issue even if a status pops it this cycle (no bypass).
  assign m_desc_valid = (state_q == ISSUE) && !fifo_full && !rst;
  assign req_fire    = s_req_valid && s_req_ready;
  assign desc_fire   = m_desc_valid && m_desc_ready;
  assign desc_last   = (rem_q == REQ_LEN_WIDTH'(chunk_q));
  assign status_pop  = s_status_valid && !fifo_empty;
  assign pcie_nxt    = pcie_q + PCIE_ADDR_WIDTH'(chunk_q);
  assign axi_nxt     = axi_q + AXI_ADDR_WIDTH'(chunk_q);
  assign rem_nxt     = rem_q - REQ_LEN_WIDTH'(chunk_q);
  assign head_dtag   = fifo_dtag[rd_ptr_q];
  assign head_rtag   = fifo_rtag[rd_ptr_q];
  assign head_last   = fifo_last[rd_ptr_q];
  // First nonzero error of the request wins.
  assign eff_err     = (err_acc_q != 4'd0) ? err_acc_q : s_status_error;

  assign m_desc_pcie_addr = pcie_q;
  assign m_desc_axi_addr  = axi_q;
  assign m_desc_len       = chunk_q;
  assign m_desc_tag       = dma_tag_q;
  assign m_cpl_valid      = cpl_valid_q;
  assign m_cpl_tag        = cpl_tag_q;
  assign m_cpl_error      = cpl_error_q;
  assign err_tag_mismatch = err_mm_q;
  assign err_unexpected   = err_unexp_q;
  assign err_zero_len     = err_zero_q;

  // Next-state logic: request FSM, chunk arithmetic, FIFO pointers, status matching.
  always_comb begin
    state_d     = state_q;
    pcie_d      = pcie_q;
    axi_d       = axi_q;
    rem_d       = rem_q;
    chunk_d     = chunk_q;
    req_tag_d   = req_tag_q;
    dma_tag_d   = dma_tag_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    err_acc_d   = err_acc_q;
    cpl_valid_d = 1'b0;
    cpl_tag_d   = cpl_tag_q;
    cpl_error_d = cpl_error_q;
    err_mm_d    = err_mm_q;
    err_unexp_d = err_unexp_q;
    err_zero_d  = err_zero_q;

    case (state_q)
      IDLE: begin
        if (req_fire) begin
          if (s_req_len == '0) begin
            err_zero_d = 1'b1;
          end else begin
            pcie_d    = s_req_pcie_addr;
            axi_d     = s_req_axi_addr;
            rem_d     = s_req_len;
            chunk_d   = chunk_len(s_req_pcie_addr[OFF_W-1:0], s_req_len);
            req_tag_d = s_req_tag;
            state_d   = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (desc_fire) begin
          dma_tag_d = dma_tag_q + DMA_TAG_WIDTH'(1);
          if (desc_last) begin
            state_d = IDLE;
          end else begin
            pcie_d  = pcie_nxt;
            axi_d   = axi_nxt;
            rem_d   = rem_nxt;
            chunk_d = chunk_len(pcie_nxt[OFF_W-1:0], rem_nxt);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (desc_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (status_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (desc_fire && !status_pop) cnt_d = cnt_q + (PTR_W+1)'(1);
    else if (!desc_fire && status_pop) cnt_d = cnt_q - (PTR_W+1)'(1);

    if (s_status_valid) begin
      if (fifo_empty) begin
        err_unexp_d = 1'b1;
      end else begin
        if (s_status_tag != head_dtag) err_mm_d = 1'b1;
        if (head_last) begin
          cpl_valid_d = 1'b1;
          cpl_tag_d   = head_rtag;
          cpl_error_d = eff_err;
          err_acc_d   = 4'd0;
        end else begin
          err_acc_d = eff_err;
        end
      end
    end
  end

  // State and control registers; reset drops all in-flight work.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pcie_q      <= '0;
      axi_q       <= '0;
      rem_q       <= '0;
      chunk_q     <= '0;
      req_tag_q   <= '0;
      dma_tag_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      err_acc_q   <= '0;
      cpl_valid_q <= 1'b0;
      cpl_tag_q   <= '0;
      cpl_error_q <= '0;
      err_mm_q    <= 1'b0;
      err_unexp_q <= 1'b0;
      err_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pcie_q      <= pcie_d;
      axi_q       <= axi_d;
      rem_q       <= rem_d;
      chunk_q     <= chunk_d;
      req_tag_q   <= req_tag_d;
      dma_tag_q   <= dma_tag_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      err_acc_q   <= err_acc_d;
      cpl_valid_q <= cpl_valid_d;
      cpl_tag_q   <= cpl_tag_d;
      cpl_error_q <= cpl_error_d;
      err_mm_q    <= err_mm_d;
      err_unexp_q <= err_unexp_d;
      err_zero_q  <= err_zero_d;
    end
  end

  // Record each issued chunk in the outstanding FIFO.
  always_ff @(posedge clk) begin
    if (desc_fire) begin
      fifo_dtag[wr_ptr_q] <= dma_tag_q;
      fifo_rtag[wr_ptr_q] <= req_tag_q;
      fifo_last[wr_ptr_q] <= desc_last;
    end
  end

endmodule

// File: tb/tb_pcie_dma_wr_splitter.sv
// Scoreboard bench for pcie_dma_wr_splitter: directed requests push expected
// descriptors/completions; a negedge monitor pops and compares them.
module tb_pcie_dma_wr_splitter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] s_req_pcie_addr = '0;
  logic [47:0] s_req_axi_addr = '0;
  logic [19:0] s_req_len = '0;
  logic [7:0]  s_req_tag = '0;
  logic        s_req_valid = 1'b0;
  logic        s_req_ready;
  logic [63:0] m_desc_pcie_addr;
  logic [47:0] m_desc_axi_addr;
  logic [15:0] m_desc_len;
  logic [7:0]  m_desc_tag;
  logic        m_desc_valid;
  logic        m_desc_ready = 1'b1;
  logic [7:0]  s_status_tag = '0;
  logic [3:0]  s_status_error = '0;
  logic        s_status_valid = 1'b0;
  logic [7:0]  m_cpl_tag;
  logic [3:0]  m_cpl_error;
  logic        m_cpl_valid;
  logic        err_tag_mismatch, err_unexpected, err_zero_len;

  pcie_dma_wr_splitter dut (
    .clk(clk), .rst(rst),
    .s_req_pcie_addr(s_req_pcie_addr), .s_req_axi_addr(s_req_axi_addr),
    .s_req_len(s_req_len), .s_req_tag(s_req_tag),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .m_desc_pcie_addr(m_desc_pcie_addr), .m_desc_axi_addr(m_desc_axi_addr),
    .m_desc_len(m_desc_len), .m_desc_tag(m_desc_tag),
    .m_desc_valid(m_desc_valid), .m_desc_ready(m_desc_ready),
    .s_status_tag(s_status_tag), .s_status_error(s_status_error),
    .s_status_valid(s_status_valid),
    .m_cpl_tag(m_cpl_tag), .m_cpl_error(m_cpl_error), .m_cpl_valid(m_cpl_valid),
    .err_tag_mismatch(err_tag_mismatch), .err_unexpected(err_unexpected),
    .err_zero_len(err_zero_len)
  );

  always #2 clk = ~clk;

  typedef struct {
    logic [63:0] pcie;
    logic [47:0] axi;
    logic [15:0] len;
    logic [7:0]  tag;
  } desc_t;

  typedef struct {
    logic [7:0] tag;
    logic [3:0] err;
  } cpl_t;

  desc_t exp_desc_q[$];
  cpl_t  exp_cpl_q[$];
  int    checks = 0;
  int    failures = 0;
  int    desc_cnt = 0;
  bit    sender_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_d(input logic [63:0] pa, input logic [47:0] aa,
                       input logic [15:0] len, input logic [7:0] tag);
    desc_t d;
    d.pcie = pa; d.axi = aa; d.len = len; d.tag = tag;
    exp_desc_q.push_back(d);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one request; optionally check descriptor valid one cycle after accept.
  task automatic send_req(input logic [63:0] pa, input logic [47:0] aa, input logic [19:0] len,
                          input logic [7:0] tag, input bit chk_dv, input bit exp_dv);
    bit done;
    done = 1'b0;
    s_req_pcie_addr = pa;
    s_req_axi_addr  = aa;
    s_req_len       = len;
    s_req_tag       = tag;
    s_req_valid     = 1'b1;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (s_req_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    s_req_valid = 1'b0;
    if (!done) chk("req_accept_timeout", 64'd0, 64'd1);
    else if (chk_dv) chk("desc_valid_after_accept", 64'(m_desc_valid), 64'(exp_dv));
  endtask

  // One-cycle status strobe; completion must appear exactly one cycle later.
  task automatic status(input logic [7:0] tag, input logic [3:0] err, input bit retire,
                        input logic [7:0] ctag, input logic [3:0] cerr);
    cpl_t c;
    if (retire) begin
      c.tag = ctag; c.err = cerr;
      exp_cpl_q.push_back(c);
    end
    s_status_tag   = tag;
    s_status_error = err;
    s_status_valid = 1'b1;
    @(posedge clk);
    #1;
    s_status_valid = 1'b0;
    chk("cpl_latency", 64'(m_cpl_valid), 64'(retire));
  endtask

  // Monitor: compare every descriptor handshake and completion with the scoreboard.
  always @(negedge clk) begin
    if (m_desc_valid && m_desc_ready) begin
      desc_cnt++;
      if (exp_desc_q.size() == 0) begin
        chk("desc_unexpected", 64'(m_desc_tag), 64'hFFFF);
      end else begin
        desc_t e;
        e = exp_desc_q.pop_front();
        chk("desc_pcie_addr", m_desc_pcie_addr, e.pcie);
        chk("desc_axi_addr", 64'(m_desc_axi_addr), 64'(e.axi));
        chk("desc_len", 64'(m_desc_len), 64'(e.len));
        chk("desc_tag", 64'(m_desc_tag), 64'(e.tag));
      end
    end
    if (m_cpl_valid) begin
      if (exp_cpl_q.size() == 0) begin
        chk("cpl_unexpected", 64'(m_cpl_tag), 64'hFFFF);
      end else begin
        cpl_t c;
        c = exp_cpl_q.pop_front();
        chk("cpl_tag", 64'(m_cpl_tag), 64'(c.tag));
        chk("cpl_error", 64'(m_cpl_error), 64'(c.err));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    // Reset state
    cycles(3);
    chk("rst_req_ready", 64'(s_req_ready), 64'd0);
    chk("rst_desc_valid", 64'(m_desc_valid), 64'd0);
    chk("rst_cpl_valid", 64'(m_cpl_valid), 64'd0);
    chk("rst_flags", {61'd0, err_tag_mismatch, err_unexpected, err_zero_len}, 64'd0);
    rst = 1'b0;
    cycles(1);
    chk("idle_req_ready", 64'(s_req_ready), 64'd1);

    // Single-chunk request
    exp_d(64'h1000, 48'h2000, 16'd256, 8'd0);
    send_req(64'h1000, 48'h2000, 20'd256, 8'd5, 1'b1, 1'b1);
    cycles(2);
    status(8'd0, 4'd0, 1'b1, 8'd5, 4'd0);

    // Boundary-crossing request split into four chunks
    exp_d(64'h0F00, 48'h8000, 16'h0100, 8'd1);
    exp_d(64'h1000, 48'h8100, 16'h1000, 8'd2);
    exp_d(64'h2000, 48'h9100, 16'h1000, 8'd3);
    exp_d(64'h3000, 48'hA100, 16'h0100, 8'd4);
    send_req(64'h0F00, 48'h8000, 20'h2200, 8'd7, 1'b1, 1'b1);
    cycles(6);
    status(8'd1, 4'd0, 1'b0, 8'd0, 4'd0);
    status(8'd2, 4'd0, 1'b0, 8'd0, 4'd0);
    status(8'd3, 4'd0, 1'b0, 8'd0, 4'd0);
    status(8'd4, 4'd0, 1'b1, 8'd7, 4'd0);

    // FIFO fill: 20 one-chunk requests with statuses withheld
    base = desc_cnt;
    for (int i = 0; i < 20; i++)
      exp_d(64'h10000 + 64'(i) * 64'h1000, 48'h20000 + 48'(i) * 48'h40, 16'd64, 8'(5 + i));
    fork
      begin
        for (int j = 0; j < 20; j++)
          send_req(64'h10000 + 64'(j) * 64'h1000, 48'h20000 + 48'(j) * 48'h40,
                   20'd64, 8'(j), 1'b0, 1'b0);
        sender_done = 1'b1;
      end
    join_none
    cycles(40);
    chk("full_desc_count", 64'(desc_cnt - base), 64'd16);
    chk("full_desc_valid_low", 64'(m_desc_valid), 64'd0);
    for (int i = 0; i < 20; i++) begin
      status(8'(5 + i), 4'd0, 1'b1, 8'(i), 4'd0);
      cycles(2);
    end
    for (int i = 0; i < 200 && !sender_done; i++) cycles(1);
    chk("sender_done", 64'(sender_done), 64'd1);
    chk("fill_desc_total", 64'(desc_cnt - base), 64'd20);

    // Error accumulation over a 3-chunk request, then a tag mismatch
    exp_d(64'h5000, 48'h0000, 16'h1000, 8'd25);
    exp_d(64'h6000, 48'h1000, 16'h1000, 8'd26);
    exp_d(64'h7000, 48'h2000, 16'h1000, 8'd27);
    send_req(64'h5000, 48'h0, 20'h3000, 8'd9, 1'b1, 1'b1);
    cycles(5);
    status(8'd25, 4'd0, 1'b0, 8'd0, 4'd0);
    status(8'd26, 4'd3, 1'b0, 8'd0, 4'd0);
    status(8'd27, 4'd5, 1'b1, 8'd9, 4'd3);
    chk("mismatch_clear", 64'(err_tag_mismatch), 64'd0);
    exp_d(64'h100, 48'h300, 16'd16, 8'd28);
    send_req(64'h100, 48'h300, 20'd16, 8'd10, 1'b1, 1'b1);
    cycles(2);
    status(8'd99, 4'd0, 1'b1, 8'd10, 4'd0);
    chk("mismatch_set", 64'(err_tag_mismatch), 64'd1);

    // Zero-length request and status with empty FIFO
    chk("zero_len_clear", 64'(err_zero_len), 64'd0);
    send_req(64'h400, 48'h0, 20'd0, 8'd11, 1'b1, 1'b0);
    chk("zero_len_set", 64'(err_zero_len), 64'd1);
    chk("zero_len_ready", 64'(s_req_ready), 64'd1);
    cycles(3);
    chk("unexp_clear", 64'(err_unexpected), 64'd0);
    status(8'h33, 4'd7, 1'b0, 8'd0, 4'd0);
    chk("unexp_set", 64'(err_unexpected), 64'd1);

    // Stalled descriptor stays stable, then reset mid-request
    m_desc_ready = 1'b0;
    send_req(64'h0800, 48'h40, 20'h1000, 8'd3, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", 64'(m_desc_valid), 64'd1);
      chk("stall_pcie", m_desc_pcie_addr, 64'h0800);
      chk("stall_axi", 64'(m_desc_axi_addr), 64'h40);
      chk("stall_len", 64'(m_desc_len), 64'h0800);
      chk("stall_tag", 64'(m_desc_tag), 64'd29);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycles(1);
    chk("rst2_desc_valid", 64'(m_desc_valid), 64'd0);
    chk("rst2_req_ready", 64'(s_req_ready), 64'd0);
    chk("rst2_desc_pcie", m_desc_pcie_addr, 64'd0);
    chk("rst2_desc_len", 64'(m_desc_len), 64'd0);
    chk("rst2_desc_tag", 64'(m_desc_tag), 64'd0);
    chk("rst2_cpl_valid", 64'(m_cpl_valid), 64'd0);
    chk("rst2_flags", {61'd0, err_tag_mismatch, err_unexpected, err_zero_len}, 64'd0);
    rst = 1'b0;
    m_desc_ready = 1'b1;
    cycles(1);
    exp_d(64'h2000, 48'h500, 16'd32, 8'd0);
    send_req(64'h2000, 48'h500, 20'd32, 8'd4, 1'b1, 1'b1);
    cycles(2);
    status(8'd0, 4'd0, 1'b1, 8'd4, 4'd0);
    cycles(3);

    chk("desc_queue_drained", 64'(exp_desc_q.size()), 64'd0);
    chk("cpl_queue_drained", 64'(exp_cpl_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
